// File: rtl/dp_share_pkg.sv
// Shared types and defaults for the datapath-sharing arbiter.
// Holds the FSM state encoding and the one-hot helper used for grants.
package dp_share_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_ABORT = 3'd4
    } state_t;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_TMO    = 31;
    localparam int MAX_REQ    = 8;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

endpackage

// File: rtl/dp_share_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate req so ptr sits at bit 0,
// take the lowest set bit, then rotate the offset back to a client index.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [PTR_W-1:0] winner,
    output logic             valid
);

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
        logic [PTR_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum >= (PTR_W+1)'(N_REQ)) begin
            wrap_add = PTR_W'(sum - (PTR_W+1)'(N_REQ));
        end else begin
            wrap_add = sum[PTR_W-1:0];
        end
    endfunction

    logic [N_REQ-1:0] rot_s;
    logic [PTR_W-1:0] off_s;
    logic             found_s;

    // Rotate, priority-encode from the bottom, rotate back.
    always_comb begin
        rot_s   = '0;
        off_s   = '0;
        found_s = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            rot_s[i] = req[wrap_add(ptr, PTR_W'(i))];
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (rot_s[i] && !found_s) begin
                off_s   = PTR_W'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
        winner = wrap_add(ptr, off_s);
        valid  = found_s;
    end

endmodule

// File: rtl/dp_share_arbiter.sv
// Round-robin front end that lends one sequenced datapath to N_REQ clients,
// with a watchdog that resets the datapath if it never reports completion.
module dp_share_arbiter
    import dp_share_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TMO    = DEF_TMO
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*DATA_W-1:0] x_in,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        done,
    output logic                    err,
    output logic [DATA_W-1:0]       result,
    output logic                    busy,
    output logic                    dp_permit,
    output logic [DATA_W-1:0]       dp_x,
    output logic                    dp_rst,
    input  logic                    dp_ready,
    input  logic                    dp_feito,
    input  logic [DATA_W-1:0]       dp_result
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = $clog2(TMO + 1);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TMO);
    localparam logic [PTR_W-1:0] LAST   = PTR_W'(N_REQ - 1);

    state_t              state_r, state_next_s;
    logic [PTR_W-1:0]    ptr_r, ptr_next_s;
    logic [PTR_W-1:0]    owner_r, owner_next_s;
    logic [N_REQ-1:0]    gnt_r, gnt_next_s;
    logic [N_REQ-1:0]    done_r, done_next_s;
    logic                err_r, err_next_s;
    logic [DATA_W-1:0]   result_r, result_next_s;
    logic [DATA_W-1:0]   dp_x_r, dp_x_next_s;
    logic                dp_rst_r, dp_rst_next_s;
    logic [WD_W-1:0]     wdog_r, wdog_next_s;
    logic                permit_s;
    logic [PTR_W-1:0]    pick_idx_s;
    logic                pick_valid_s;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_r),
        .winner (pick_idx_s),
        .valid  (pick_valid_s)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, next-register values and the combinational permit strobe.
    always_comb begin
        state_next_s  = state_r;
        ptr_next_s    = ptr_r;
        owner_next_s  = owner_r;
        gnt_next_s    = gnt_r;
        done_next_s   = '0;
        err_next_s    = err_r;
        result_next_s = result_r;
        dp_x_next_s   = dp_x_r;
        dp_rst_next_s = 1'b0;
        wdog_next_s   = wdog_r;
        permit_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pick_valid_s) begin
                    owner_next_s = pick_idx_s;
                    gnt_next_s   = N_REQ'(onehot(3'(pick_idx_s)));
                    dp_x_next_s  = x_in[pick_idx_s*DATA_W +: DATA_W];
                    state_next_s = ST_ISSUE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                permit_s = dp_ready;
                if (dp_ready) begin
                    wdog_next_s  = '0;
                    state_next_s = ST_WAIT;
                end else begin
                    state_next_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                wdog_next_s = (wdog_r == WD_MAX) ? wdog_r : wdog_r + 1'b1;
                // Completion beats a coincident timeout.
                if (dp_feito) begin
                    result_next_s = dp_result;
                    done_next_s   = gnt_r;
                    err_next_s    = 1'b0;
                    state_next_s  = ST_RESP;
                end else if (wdog_r == WD_MAX) begin
                    dp_rst_next_s = 1'b1;
                    state_next_s  = ST_ABORT;
                end else begin
                    state_next_s  = ST_WAIT;
                end
            end
            ST_ABORT: begin
                result_next_s = '0;
                done_next_s   = gnt_r;
                err_next_s    = 1'b1;
                state_next_s  = ST_RESP;
            end
            ST_RESP: begin
                gnt_next_s   = '0;
                err_next_s   = 1'b0;
                ptr_next_s   = (owner_r == LAST) ? '0 : owner_r + 1'b1;
                state_next_s = ST_IDLE;
            end
            default: begin
                gnt_next_s   = '0;
                err_next_s   = 1'b0;
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, rotation pointer and watchdog.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r    <= '0;
            owner_r  <= '0;
            gnt_r    <= '0;
            done_r   <= '0;
            err_r    <= 1'b0;
            result_r <= '0;
            dp_x_r   <= '0;
            dp_rst_r <= 1'b0;
            wdog_r   <= '0;
        end else begin
            ptr_r    <= ptr_next_s;
            owner_r  <= owner_next_s;
            gnt_r    <= gnt_next_s;
            done_r   <= done_next_s;
            err_r    <= err_next_s;
            result_r <= result_next_s;
            dp_x_r   <= dp_x_next_s;
            dp_rst_r <= dp_rst_next_s;
            wdog_r   <= wdog_next_s;
        end
    end

    assign gnt       = gnt_r;
    assign done      = done_r;
    assign err       = err_r;
    assign result    = result_r;
    assign dp_x      = dp_x_r;
    assign dp_rst    = dp_rst_r;
    assign dp_permit = permit_s;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_dp_share_arbiter.sv
// Directed plus randomized bench for dp_share_arbiter with a behavioural
// datapath (squares its operand after a chosen latency) and a rotation model.
module tb_dp_share_arbiter;

    localparam int N   = 4;
    localparam int W   = 16;
    localparam int TMO = 31;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] x_in;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           err;
    logic [W-1:0]   result;
    logic           busy;
    logic           dp_permit;
    logic [W-1:0]   dp_x;
    logic           dp_rst;
    logic           dp_ready;
    logic           dp_feito;
    logic [W-1:0]   dp_result;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference state: rotation pointer and datapath behaviour
    int       mptr     = 0;
    int       dp_cnt   = 0;
    int       lat_cfg  = 8;
    bit       hang     = 1'b0;
    bit       ready_en = 1'b1;
    logic     pre_permit;
    logic [W-1:0] pre_x;
    logic [W-1:0] dp_xl = '0;

    dp_share_arbiter #(.N_REQ(N), .DATA_W(W), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .x_in      (x_in),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .result    (result),
        .busy      (busy),
        .dp_permit (dp_permit),
        .dp_x      (dp_x),
        .dp_rst    (dp_rst),
        .dp_ready  (dp_ready),
        .dp_feito  (dp_feito),
        .dp_result (dp_result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int j = 0; j < N; j++) begin
            if (r[(p + j) % N]) return (p + j) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] sq(input logic [W-1:0] v);
        return v * v;
    endfunction

    // One clock: sample permit before the edge, then advance the datapath model.
    task automatic tick();
        @(negedge clk);
        pre_permit = dp_permit;
        pre_x      = dp_x;
        @(posedge clk);
        #1;
        if (dp_rst === 1'b1) dp_cnt = 0;
        else if (pre_permit === 1'b1) begin
            dp_cnt = lat_cfg;
            dp_xl  = pre_x;
        end else if (dp_cnt > 0) dp_cnt--;
        dp_feito  = (dp_cnt == 1) && !hang;
        dp_result = dp_feito ? sq(dp_xl) : W'($urandom);
        dp_ready  = (dp_cnt == 0) && ready_en;
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_gnt"},    gnt, 0);
        check({tag, "_done"},   done, 0);
        check({tag, "_err"},    err, 0);
        check({tag, "_busy"},   busy, 0);
        check({tag, "_permit"}, dp_permit, 0);
        check({tag, "_dprst"},  dp_rst, 0);
    endtask

    task automatic do_run(input logic [N-1:0] rq, input int lat, input int rdy_dly,
                          input bit hg, input int drop_at);
        logic [W-1:0] xs [N];
        logic [W-1:0] exp_res;
        int w, pc, rc, dc, npermit;
        for (int i = 0; i < N; i++) xs[i] = W'($urandom);
        x_in     = {xs[3], xs[2], xs[1], xs[0]};
        lat_cfg  = lat;
        hang     = hg;
        ready_en = (rdy_dly == 0);
        req      = rq;
        w        = pick(rq, mptr);
        exp_res  = hg ? '0 : sq(xs[w]);
        tick();
        check("gnt", gnt, 1 << w);
        check("dp_x", dp_x, xs[w]);
        check("busy", busy, 1);
        pc = -1; rc = -1; dc = -1; npermit = 0;
        for (int c = 0; c < 200 && dc < 0; c++) begin
            if (c > 0) tick();
            if (dp_permit === 1'b1) begin
                npermit++;
                if (pc < 0) pc = c;
            end
            if (dp_rst === 1'b1 && rc < 0) rc = c;
            if (done !== '0) begin
                dc = c;
                check("done", done, 1 << w);
                check("result", result, exp_res);
                check("err", err, hg);
            end else if (c < rdy_dly) begin
                check("issue_hold", {busy, gnt}, {1'b1, 4'(1 << w)});
            end
            if (c == 1) x_in = {$urandom, $urandom};
            if (rdy_dly > 0 && c == rdy_dly - 1) ready_en = 1'b1;
            if (c == drop_at) req = rq & ~(4'(1 << w));
        end
        check("done_seen", dc >= 0, 1);
        check("permits", npermit, 1);
        check("permit_at", pc, rdy_dly);
        if (hg) begin
            check("wdog_edges", rc - pc - 1, TMO + 1);
            check("abort_resp", dc - rc, 1);
        end else begin
            check("latency", dc - pc, lat + 1);
        end
        tick();
        check_quiet("after");
        mptr = (w + 1) % N;
    endtask

    initial begin
        rst = 1'b1; req = '0; x_in = '0;
        dp_ready = 1'b1; dp_feito = 1'b0; dp_result = '0;
        tick();
        tick();
        check_quiet("reset");
        check("reset_result", result, 0);
        check("reset_dpx", dp_x, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // single request from client 1, operand 5 -> 0x19
        begin
            logic [W-1:0] xs1;
            req = 4'b0010; x_in = '0; x_in[W +: W] = 16'h0005;
            lat_cfg = 8; hang = 1'b0; ready_en = 1'b1;
            tick();
            check("single_gnt", gnt, 4'b0010);
            check("single_permit", dp_permit, 1);
            xs1 = 16'h0000;
            for (int c = 0; c < 20 && done === '0; c++) tick();
            check("single_done", done, 4'b0010);
            check("single_result", result, 16'h0019);
            check("single_err", err, xs1[0]);
            tick();
            check_quiet("single_end");
            mptr = 2;
        end

        // client 2 drops its request mid-run; pending client 3 follows
        do_run(4'b1100, 8, 0, 1'b0, 3);
        do_run(4'b1000, 6, 0, 1'b0, -1);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        mptr = 0;
        for (int k = 0; k < 8; k++) begin
            do_run(4'b1111, $urandom_range(1, 10), 0, 1'b0, -1);
            check("fair_order", (mptr + N - 1) % N, k % N);
        end

        // datapath busy for 5 cycles after grant
        do_run(4'b0001, 8, 5, 1'b0, -1);
        // datapath hangs -> watchdog abort
        do_run(4'b0010, 8, 0, 1'b1, -1);

        // reset in the middle of WAIT; late feito must be ignored
        req = 4'b0100; x_in = {$urandom, $urandom};
        lat_cfg = 8; hang = 1'b0; ready_en = 1'b1;
        tick();
        check("rw_gnt", gnt, 4'b0100);
        tick();
        tick();
        rst = 1'b1; req = '0;
        tick();
        rst = 1'b0;
        check_quiet("rw_reset");
        check("rw_result", result, 0);
        check("rw_dpx", dp_x, 0);
        mptr = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            check("rw_ignore", {busy, done}, 5'b0);
        end
        do_run(4'b1111, 4, 0, 1'b0, -1);

        for (int k = 0; k < 16; k++) begin
            do_run(4'($urandom_range(1, 15)), $urandom_range(1, 12), $urandom_range(0, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 15));
            req = '0;
            tick();
            check("rand_idle", busy, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
